// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// rv32i_pkg + memory_stage
//
// rv32i_pkg: datapath width and ALU operation encoding shared by the core.
//
// memory_stage: execute / memory / writeback slice of a 5-stage RV32I pipe.
// The E stage is combinational and contains the forwarding muxes, the
// operand-B immediate select and the ALU. Two register stages follow:
// E->M, then M->W. The M stage holds a small data memory.
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset (clears pipe and memory)
//   resultsrcE   instruction in E is a load
//   memwriteE    instruction in E is a store
//   alusrcE      ALU operand B: 1 = immextE, 0 = forwarded Rd2E
//   regwriteE    instruction in E writes the register file
//   alu_ctrlE    ALU operation
//   srcA         register value for operand A (pre-forwarding)
//   Rd2E         register value for operand B / store data (pre-forwarding)
//   immextE      sign-extended immediate
//   RdE          destination register of the instruction in E
//   rs1E, rs2E   source registers of the instruction in E
//   aluresultM   registered ALU result in M
//   addr_3       writeback destination register (RdW)
//   wd_3         writeback data (resultW)
//   we           writeback enable (regwriteW)
// ---------------------------------------------------------------------------
package rv32i_pkg;
    localparam int DPW = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;
endpackage

module memory_stage
    import rv32i_pkg::*;
#(
    parameter int ADW = 5,
    parameter int DMW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic           alusrcE,
    input  logic           regwriteE,
    input  alu_op_t        alu_ctrlE,
    input  logic [DPW-1:0] srcA,
    input  logic [DPW-1:0] Rd2E,
    input  logic [DPW-1:0] immextE,
    input  logic [ADW-1:0] RdE,
    input  logic [ADW-1:0] rs1E,
    input  logic [ADW-1:0] rs2E,
    output logic [DPW-1:0] aluresultM,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3,
    output logic           we
);

    localparam int DEPTH = 2 ** DMW;

    // E->M pipeline register
    logic [DPW-1:0] aluresult_m_q, aluresult_m_d;
    logic [DPW-1:0] writedata_m_q, writedata_m_d;
    logic [ADW-1:0] rd_m_q, rd_m_d;
    logic           regwrite_m_q, regwrite_m_d;
    logic           resultsrc_m_q, resultsrc_m_d;
    logic           memwrite_m_q, memwrite_m_d;

    // M->W pipeline register
    logic [DPW-1:0] result_w_q, result_w_d;
    logic [ADW-1:0] rd_w_q, rd_w_d;
    logic           regwrite_w_q, regwrite_w_d;

    // Data memory
    logic [DPW-1:0] mem_q [DEPTH];
    logic [DMW-1:0] mem_idx;
    logic [DPW-1:0] read_data;

    // E-stage combinational signals
    logic [DPW-1:0] fwd_a;
    logic [DPW-1:0] fwd_b;
    logic [DPW-1:0] op_b;
    logic [DPW-1:0] alu_result;

    // Forwarding: M wins over W; x0 is never a forwarding source because
    // writes to it are discarded by the register file.
    always_comb begin
        fwd_a = srcA;
        if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs1E)) begin
            fwd_a = aluresult_m_q;
        end else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs1E)) begin
            fwd_a = result_w_q;
        end

        fwd_b = Rd2E;
        if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs2E)) begin
            fwd_b = aluresult_m_q;
        end else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs2E)) begin
            fwd_b = result_w_q;
        end

        op_b = alusrcE ? immextE : fwd_b;
    end

    // ALU; unused encodings produce zero so bubbles stay clean.
    always_comb begin
        alu_result = '0;
        unique case (alu_ctrlE)
            ALU_ADD: alu_result = fwd_a + op_b;
            ALU_SUB: alu_result = fwd_a - op_b;
            ALU_AND: alu_result = fwd_a & op_b;
            ALU_OR:  alu_result = fwd_a | op_b;
            ALU_SLT: alu_result = ($signed(fwd_a) < $signed(op_b)) ?
                                  {{(DPW-1){1'b0}}, 1'b1} : '0;
            default: alu_result = '0;
        endcase
    end

    // Word index ignores the byte offset and anything above the memory
    // size, so out-of-range addresses wrap.
    always_comb begin
        mem_idx   = aluresult_m_q[DMW+1:2];
        read_data = mem_q[mem_idx];
    end

    // Next-state values for both pipeline registers.
    always_comb begin
        aluresult_m_d = alu_result;
        writedata_m_d = fwd_b;
        rd_m_d        = RdE;
        regwrite_m_d  = regwriteE;
        resultsrc_m_d = resultsrcE;
        memwrite_m_d  = memwriteE;

        result_w_d    = resultsrc_m_q ? read_data : aluresult_m_q;
        rd_w_d        = rd_m_q;
        regwrite_w_d  = regwrite_m_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluresult_m_q <= '0;
            writedata_m_q <= '0;
            rd_m_q        <= '0;
            regwrite_m_q  <= 1'b0;
            resultsrc_m_q <= 1'b0;
            memwrite_m_q  <= 1'b0;
            result_w_q    <= '0;
            rd_w_q        <= '0;
            regwrite_w_q  <= 1'b0;
        end else begin
            aluresult_m_q <= aluresult_m_d;
            writedata_m_q <= writedata_m_d;
            rd_m_q        <= rd_m_d;
            regwrite_m_q  <= regwrite_m_d;
            resultsrc_m_q <= resultsrc_m_d;
            memwrite_m_q  <= memwrite_m_d;
            result_w_q    <= result_w_d;
            rd_w_q        <= rd_w_d;
            regwrite_w_q  <= regwrite_w_d;
        end
    end

    // Reset clears every word and blocks a store that is in M on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memwrite_m_q) begin
            mem_q[mem_idx] <= writedata_m_q;
        end
    end

    assign aluresultM = aluresult_m_q;
    assign addr_3     = rd_w_q;
    assign wd_3       = result_w_q;
    assign we         = regwrite_w_q;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage: directed self-checking bench for memory_stage.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_memory_stage;
    import rv32i_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           resultsrcE;
    logic           memwriteE;
    logic           alusrcE;
    logic           regwriteE;
    alu_op_t        alu_ctrlE;
    logic [DPW-1:0] srcA;
    logic [DPW-1:0] Rd2E;
    logic [DPW-1:0] immextE;
    logic [4:0]     RdE;
    logic [4:0]     rs1E;
    logic [4:0]     rs2E;
    logic [DPW-1:0] aluresultM;
    logic [4:0]     addr_3;
    logic [DPW-1:0] wd_3;
    logic           we;

    int tests_run;
    int tests_failed;

    memory_stage #(.ADW(5), .DMW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .alusrcE    (alusrcE),
        .regwriteE  (regwriteE),
        .alu_ctrlE  (alu_ctrlE),
        .srcA       (srcA),
        .Rd2E       (Rd2E),
        .immextE    (immextE),
        .RdE        (RdE),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .aluresultM (aluresultM),
        .addr_3     (addr_3),
        .wd_3       (wd_3),
        .we         (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic asrc, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic rw,
                         input logic ld, input logic st);
        alu_ctrlE  = op;
        srcA       = a;
        Rd2E       = b;
        immextE    = imm;
        alusrcE    = asrc;
        RdE        = rd;
        rs1E       = r1;
        rs2E       = r2;
        regwriteE  = rw;
        resultsrcE = ld;
        memwriteE  = st;
    endtask

    task automatic bubble();
        drive(ALU_ADD, 0, 0, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        bubble();
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(ALU_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #12;
        tests_run++;
        if (aluresultM !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_aluresultM: got %h expected %h", aluresultM, 32'd0);
        end
        tests_run++;
        if (addr_3 !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr_3: got %0d expected 0", addr_3);
        end
        tests_run++;
        if (wd_3 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wd_3: got %h expected 0", wd_3);
        end
        tests_run++;
        if (we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_we: got %b expected 0", we);
        end
        bubble();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (aluresultM !== 32'd12) begin
            tests_failed++;
            $display("[TB] FAIL add_aluresultM: got %h expected %h", aluresultM, 32'd12);
        end
        bubble();
        tick();
        tests_run++;
        if (addr_3 !== 5'd3 || wd_3 !== 32'd12 || we !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL add_writeback: got addr=%0d wd=%h we=%b expected addr=3 wd=%h we=1",
                     addr_3, wd_3, we, 32'd12);
        end
        flush();
    endtask

    task automatic test_alu_ops();
        alu_op_t        ops  [8];
        logic [31:0]    av   [8];
        logic [31:0]    bv   [8];
        logic [31:0]    imm  [8];
        logic           asrc [8];
        logic [31:0]    expv [8];
        ops[0] = ALU_SUB; av[0] = 32'd0;        bv[0] = 32'd1;        imm[0] = 0;      asrc[0] = 0; expv[0] = 32'hFFFFFFFF;
        ops[1] = ALU_SLT; av[1] = 32'hFFFFFFFF; bv[1] = 32'd1;        imm[1] = 0;      asrc[1] = 0; expv[1] = 32'd1;
        ops[2] = ALU_SLT; av[2] = 32'd1;        bv[2] = 32'hFFFFFFFF; imm[2] = 0;      asrc[2] = 0; expv[2] = 32'd0;
        ops[3] = ALU_AND; av[3] = 32'hF0F0F0F0; bv[3] = 32'hFF00FF00; imm[3] = 0;      asrc[3] = 0; expv[3] = 32'hF000F000;
        ops[4] = ALU_OR;  av[4] = 32'hF0F0F0F0; bv[4] = 32'h0000FF00; imm[4] = 0;      asrc[4] = 0; expv[4] = 32'hF0F0FFF0;
        ops[5] = ALU_ADD; av[5] = 32'hFFFFFFFF; bv[5] = 32'd2;        imm[5] = 0;      asrc[5] = 0; expv[5] = 32'd1;
        ops[6] = ALU_ADD; av[6] = 32'd100;      bv[6] = 32'd999;      imm[6] = 32'd20; asrc[6] = 1; expv[6] = 32'd120;
        ops[7] = alu_op_t'(3'b111); av[7] = 32'd3; bv[7] = 32'd4;     imm[7] = 0;      asrc[7] = 0; expv[7] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], av[i], bv[i], imm[i], asrc[i], 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            tick();
            tests_run++;
            if (aluresultM !== expv[i]) begin
                tests_failed++;
                $display("[TB] FAIL alu_op_%0d: got %h expected %h", i, aluresultM, expv[i]);
            end
        end
        flush();
    endtask

    task automatic test_store_load();
        // store 0xDEADBEEF at byte address 8+4 = 12 (word 3)
        drive(ALU_ADD, 32'd8, 32'hDEADBEEF, 32'd4, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        bubble();
        tick();
        tests_run++;
        if (we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL store_no_we: got %b expected 0", we);
        end
        drive(ALU_ADD, 32'd8, 32'd0, 32'd4, 1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bubble();
        tick();
        tests_run++;
        if (wd_3 !== 32'hDEADBEEF || addr_3 !== 5'd5 || we !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_same_addr: got wd=%h addr=%0d we=%b expected wd=deadbeef addr=5 we=1",
                     wd_3, addr_3, we);
        end
        // 0x100 + 0xC = 0x10C wraps to word 3
        drive(ALU_ADD, 32'h100, 32'd0, 32'hC, 1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bubble();
        tick();
        tests_run++;
        if (wd_3 !== 32'hDEADBEEF || addr_3 !== 5'd6) begin
            tests_failed++;
            $display("[TB] FAIL load_wrap: got wd=%h addr=%0d expected wd=deadbeef addr=6", wd_3, addr_3);
        end
        // word 4 was never written
        drive(ALU_ADD, 32'd16, 32'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bubble();
        tick();
        tests_run++;
        if (wd_3 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL load_unwritten: got %h expected 0", wd_3);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        // x1 = 2+3 ; x2 = x1+x1 (M forwarding)
        drive(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (aluresultM !== 32'd10) begin
            tests_failed++;
            $display("[TB] FAIL fwd_m: got %0d expected 10", aluresultM);
        end
        flush();
        // same pair with a bubble: W forwarding
        drive(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        bubble();
        tick();
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (aluresultM !== 32'd10) begin
            tests_failed++;
            $display("[TB] FAIL fwd_w: got %0d expected 10", aluresultM);
        end
        flush();
        // x1=5 in W, x1=20 in M: M must win -> 20+20
        drive(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ALU_ADD, 32'd10, 32'd10, 32'd0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd3, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (aluresultM !== 32'd40) begin
            tests_failed++;
            $display("[TB] FAIL fwd_priority: got %0d expected 40", aluresultM);
        end
        flush();
    endtask

    task automatic test_rd_zero();
        // write to x0 in M must not be forwarded
        drive(ALU_ADD, 32'd7, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (aluresultM !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL x0_no_fwd_m: got %0d expected 2", aluresultM);
        end
        flush();
        // write to x0 in W must not be forwarded
        drive(ALU_ADD, 32'd7, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        bubble();
        tick();
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (aluresultM !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL x0_no_fwd_w: got %0d expected 2", aluresultM);
        end
        flush();
    endtask

    task automatic test_reset_midflight();
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        // store 0xCAFEF00D to byte address 20 (word 5)
        drive(ALU_ADD, 32'd0, 32'hCAFEF00D, 32'd20, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        bubble();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (aluresultM !== 32'd0 || addr_3 !== 5'd0 || wd_3 !== 32'd0 || we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midflight_reset: got alu=%h addr=%0d wd=%h we=%b expected all zero",
                     aluresultM, addr_3, wd_3, we);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_we_1: got %b expected 0", we);
        end
        tick();
        tests_run++;
        if (we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_we_2: got %b expected 0", we);
        end
        // store to word 5 was suppressed by reset
        drive(ALU_ADD, 32'd20, 32'd0, 32'd0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bubble();
        tick();
        tests_run++;
        if (wd_3 !== 32'd0 || we !== 1'b1 || addr_3 !== 5'd7) begin
            tests_failed++;
            $display("[TB] FAIL suppressed_store: got wd=%h we=%b addr=%0d expected wd=0 we=1 addr=7",
                     wd_3, we, addr_3);
        end
        // word 3 (previously 0xDEADBEEF) was cleared by reset
        drive(ALU_ADD, 32'd12, 32'd0, 32'd0, 1'b0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bubble();
        tick();
        tests_run++;
        if (wd_3 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL mem_cleared: got %h expected 0", wd_3);
        end
        flush();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bubble();
        test_reset();
        test_add();
        test_alu_ops();
        test_store_load();
        test_back_to_back();
        test_rd_zero();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
